// File: rtl/stage4_decode_queue.sv
// Decode-to-execute instruction queue: circular buffer with stall hold, flush,
// registered full flag (no full-bypass) and a sticky overflow flag.
module stage4_decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       queue_wen,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       stall_queue,
  input  logic                       flush_queue,
  output logic                       is_queue_full,
  output logic [WIDTH-1:0]           rdata,
  output logic                       rvalid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow_err
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW:0]      occ;
  logic             ovf;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             enq;
  logic             deq;

  assign is_queue_full = (occ == (PW+1)'(DEPTH));
  assign rvalid        = (occ != '0);
  assign rdata         = mem[rptr];
  assign count         = occ;
  assign overflow_err  = ovf;

  // Acceptance uses the registered full flag, so a same-cycle dequeue never frees a slot for a write.
  always_comb begin
    enq = queue_wen && !is_queue_full && !flush_queue;
    deq = rvalid && !stall_queue && !flush_queue;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      ovf  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_queue) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (queue_wen && is_queue_full) ovf <= 1'b1;
      if (enq) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (deq) rptr <= rptr + 1'b1;
      case ({enq, deq})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: doc/stage4_decode_queue.md
STAGE4_DECODE_QUEUE -- requirements
Module: stage4_decode_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: number of entries; power of two, at least 2.
REQ-002 The block SHALL have parameter WIDTH, default 64: bits per decoded-instruction entry.
REQ-003 The block SHALL have port CLK, input, width 1: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port nRST, input, width 1: asynchronous active-low reset.
REQ-005 The block SHALL have port queue_wen, input, width 1: decode requests an enqueue this cycle.
REQ-006 The block SHALL have port wdata, input, width WIDTH: entry to enqueue.
REQ-007 The block SHALL have port stall_queue, input, width 1: hazard unit holds the head entry (no dequeue).
REQ-008 The block SHALL have port flush_queue, input, width 1: hazard unit discards all entries.
REQ-009 The block SHALL have port is_queue_full, output, width 1: count equals DEPTH.
REQ-010 The block SHALL have port rdata, output, width WIDTH: head entry presented to execute.
REQ-011 The block SHALL have port rvalid, output, width 1: head entry is valid.
REQ-012 The block SHALL have port count, output, width clog2(DEPTH)+1: current occupancy.
REQ-013 The block SHALL have port overflow_err, output, width 1: sticky flag for an enqueue attempted while full.

Function
REQ-014 Storage SHALL be a circular buffer with a write pointer and a read pointer, each clog2(DEPTH) bits, incrementing modulo DEPTH (natural wrap from DEPTH-1 to 0).
REQ-015 is_queue_full, rvalid and rdata SHALL be combinational from registered state: is_queue_full = (count == DEPTH), rvalid = (count != 0), rdata = entry at the read pointer.
REQ-016 A dequeue SHALL occur in a cycle iff rvalid = 1 and stall_queue = 0 and flush_queue = 0; the read pointer advances by 1.
REQ-017 An enqueue SHALL occur in a cycle iff queue_wen = 1, is_queue_full = 0 and flush_queue = 0; wdata is written at the write pointer, which then advances by 1.
REQ-018 Enqueue SHALL be decided on the registered full flag: when full, queue_wen is not accepted even if a dequeue occurs in the same cycle (no full-bypass).
REQ-019 Simultaneous enqueue and dequeue SHALL leave count unchanged; enqueue alone adds 1; dequeue alone subtracts 1.
REQ-020 An enqueue into an empty queue SHALL make that entry visible on rdata/rvalid the next cycle (1-cycle latency, no write-through bypass).
REQ-021 stall_queue SHALL hold rdata, rvalid and the read pointer stable, and SHALL NOT block enqueue.
REQ-022 flush_queue SHALL have priority over all other inputs: next cycle both pointers = 0, count = 0, rvalid = 0; any same-cycle queue_wen is discarded.
REQ-023 queue_wen = 1 while is_queue_full = 1 and flush_queue = 0 SHALL set overflow_err = 1; the entry is dropped and queue state is unchanged.
REQ-024 overflow_err SHALL remain 1 until reset; flush_queue SHALL NOT clear it.
REQ-025 A dequeue attempt on an empty queue (stall_queue = 0, rvalid = 0) SHALL be a no-op.

Reset
REQ-026 While nRST = 0, the block SHALL asynchronously force both pointers to 0, count = 0, is_queue_full = 0, rvalid = 0, overflow_err = 0 and all storage entries to 0 (rdata = 0).
REQ-027 Assertion of reset mid-operation SHALL discard all entries immediately.
REQ-028 The first enqueue SHALL be accepted on the first rising edge after nRST deasserts.

Verification
REQ-029 Scenario: after reset, enqueue A, B, C, D on consecutive cycles with stall_queue = 1 -> count = 4 and is_queue_full = 1 one cycle after D; rdata = A throughout.
REQ-030 Scenario: full queue, queue_wen = 1 with E, stall_queue = 0 -> A dequeued, E dropped, count = 3, overflow_err = 1 and stays 1.
REQ-031 Scenario: 10 enqueue+dequeue pairs streaming with DEPTH = 4 -> pointers wrap, rdata order matches enqueue order exactly, count constant.
REQ-032 Scenario: count = 3 with queue_wen = 1 and flush_queue = 1 in the same cycle -> next cycle count = 0, rvalid = 0; a subsequent enqueue of F appears at rdata one cycle later.
REQ-033 Scenario: empty queue, enqueue G with stall_queue = 0 -> rvalid = 1, rdata = G the next cycle, then rvalid = 0 the cycle after.
REQ-034 Scenario: nRST pulsed low asynchronously between edges while count = 2 -> outputs reach their reset values without waiting for a clock edge.
